// File: rtl/wb_write_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : wb_write_serializer
//  Description : Writeback serializer for the 2-way core. Accepts up to two
//                retiring results per cycle (lane 0 older, lane 1 younger),
//                queues them in program order and drains exactly one per
//                cycle into the single register-file write port. A two-port
//                forwarding lookup exposes values still pending in the queue.
//
//  Ports
//    clk                       system clock, all state on posedge
//    Reset                     synchronous active-high reset
//    wb_valid0/wb_reg0/wb_data0  lane 0 (older) retiring result
//    wb_valid1/wb_reg1/wb_data1  lane 1 (younger) retiring result
//    in_ready                  queue has room for a full pair this cycle
//    RegWrite                  register file write enable (queue non-empty)
//    WriteReg_WB / WriteData   head entry destination / data, 0 when empty
//    q_reg0 -> q_hit0/q_data0  forwarding lookup A (rs)
//    q_reg1 -> q_hit1/q_data1  forwarding lookup B (rt)
//    busy                      queue non-empty
//
//  Revision    : 1.0  initial release
// ============================================================================
module wb_write_serializer #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic        clk,
    input  logic        Reset,

    input  logic        wb_valid0,
    input  logic [4:0]  wb_reg0,
    input  logic [31:0] wb_data0,
    input  logic        wb_valid1,
    input  logic [4:0]  wb_reg1,
    input  logic [31:0] wb_data1,

    output logic        in_ready,

    output logic        RegWrite,
    output logic [4:0]  WriteReg_WB,
    output logic [31:0] WriteData,

    input  logic [4:0]  q_reg0,
    output logic        q_hit0,
    output logic [31:0] q_data0,
    input  logic [4:0]  q_reg1,
    output logic        q_hit1,
    output logic [31:0] q_data1,

    output logic        busy
);

    // A full pair fits while count <= DEPTH-2.
    localparam logic [AW:0] c_READY_MAX = (AW+1)'(DEPTH - 2);

    // ------------------------------------------------------------------
    // Storage and pointers
    // ------------------------------------------------------------------
    logic [4:0]    r_reg  [DEPTH];
    logic [31:0]   r_data [DEPTH];
    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [AW:0]   r_count;

    logic          w_ready;
    logic          w_push0;
    logic          w_push1;
    logic          w_pop;
    logic [AW:0]   w_npush;
    logic [AW-1:0] w_slot1;
    logic          w_nonempty;

    // Registered count only: a same-cycle pop earns no extra room.
    assign w_ready    = (r_count <= c_READY_MAX);
    assign w_nonempty = (r_count != '0);

    // Writes to $0 are architecturally dead, so they never occupy a slot.
    assign w_push0 = w_ready & wb_valid0 & (wb_reg0 != 5'd0);
    assign w_push1 = w_ready & wb_valid1 & (wb_reg1 != 5'd0);
    assign w_pop   = w_nonempty;

    assign w_npush = (AW+1)'(w_push0) + (AW+1)'(w_push1);

    // Lane 1 lands right behind lane 0, or at the tail when lane 0 is absent.
    assign w_slot1 = r_tail + AW'(w_push0);

    always_ff @(posedge clk) begin
        if (Reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + AW'(w_pop);
            r_tail  <= r_tail + w_npush[AW-1:0];
            r_count <= r_count + w_npush - (AW+1)'(w_pop);
        end
    end

    // Entry payload needs no reset: liveness is tracked by r_count alone.
    always_ff @(posedge clk) begin
        if (!Reset) begin
            if (w_push0) begin
                r_reg[r_tail]  <= wb_reg0;
                r_data[r_tail] <= wb_data0;
            end
            if (w_push1) begin
                r_reg[w_slot1]  <= wb_reg1;
                r_data[w_slot1] <= wb_data1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Age-ordered view of the queue: index 0 is the head (oldest).
    // ------------------------------------------------------------------
    logic [AW-1:0] w_age_slot [DEPTH];
    logic          w_age_live [DEPTH];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_age
            assign w_age_slot[gi] = r_head + AW'(gi);
            assign w_age_live[gi] = ((AW+1)'(gi) < r_count);
        end
    endgenerate

    // ------------------------------------------------------------------
    // Forwarding lookup: scan oldest to youngest so the last match wins,
    // which yields the value nearest the tail.
    // ------------------------------------------------------------------
    logic        w_hit0;
    logic [31:0] w_fwd0;
    logic        w_hit1;
    logic [31:0] w_fwd1;

    always_comb begin
        w_hit0 = 1'b0;
        w_fwd0 = '0;
        w_hit1 = 1'b0;
        w_fwd1 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_age_live[i] && (q_reg0 != 5'd0) &&
                (r_reg[w_age_slot[i]] == q_reg0)) begin
                w_hit0 = 1'b1;
                w_fwd0 = r_data[w_age_slot[i]];
            end
            if (w_age_live[i] && (q_reg1 != 5'd0) &&
                (r_reg[w_age_slot[i]] == q_reg1)) begin
                w_hit1 = 1'b1;
                w_fwd1 = r_data[w_age_slot[i]];
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign in_ready    = w_ready;
    assign busy        = w_nonempty;
    assign RegWrite    = w_nonempty;
    // Head payload is stale when empty, so it is masked to 0.
    assign WriteReg_WB = w_nonempty ? r_reg[r_head]  : 5'd0;
    assign WriteData   = w_nonempty ? r_data[r_head] : 32'd0;

    assign q_hit0  = w_hit0;
    assign q_data0 = w_fwd0;
    assign q_hit1  = w_hit1;
    assign q_data1 = w_fwd1;

endmodule
`default_nettype wire

// File: tb/tb_wb_write_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wb_write_serializer
//  Description : Self-checking bench for wb_write_serializer. A queue-based
//                reference model follows the retire/drain rules and every
//                scenario task compares DUT outputs against it or against
//                fixed expected write sequences.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_wb_write_serializer;

    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic        clk = 1'b0;
    logic        Reset;
    logic        wb_valid0, wb_valid1;
    logic [4:0]  wb_reg0, wb_reg1;
    logic [31:0] wb_data0, wb_data1;
    logic        in_ready, RegWrite, busy;
    logic [4:0]  WriteReg_WB;
    logic [31:0] WriteData;
    logic [4:0]  q_reg0, q_reg1;
    logic        q_hit0, q_hit1;
    logic [31:0] q_data0, q_data1;

    always #5 clk = ~clk;

    wb_write_serializer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .Reset(Reset),
        .wb_valid0(wb_valid0), .wb_reg0(wb_reg0), .wb_data0(wb_data0),
        .wb_valid1(wb_valid1), .wb_reg1(wb_reg1), .wb_data1(wb_data1),
        .in_ready(in_ready),
        .RegWrite(RegWrite), .WriteReg_WB(WriteReg_WB), .WriteData(WriteData),
        .q_reg0(q_reg0), .q_hit0(q_hit0), .q_data0(q_data0),
        .q_reg1(q_reg1), .q_hit1(q_hit1), .q_data1(q_data1),
        .busy(busy)
    );

    // ------------------------------------------------------------------
    // Reference model: a program-order queue of {reg, data}.
    // ------------------------------------------------------------------
    logic [36:0] mq[$];
    logic        m_acc;
    int          n_vec = 0;
    int          n_err = 0;

    function automatic logic m_ready();
        return (DEPTH - mq.size()) >= 2;
    endfunction

    function automatic logic [4:0] m_head_r();
        return (mq.size() > 0) ? mq[0][36:32] : 5'd0;
    endfunction

    function automatic logic [31:0] m_head_d();
        return (mq.size() > 0) ? mq[0][31:0] : 32'd0;
    endfunction

    // {hit, data} of the youngest pending entry for r.
    function automatic logic [32:0] m_look(input logic [4:0] r);
        logic [32:0] res = 33'd0;
        if (r != 5'd0)
            for (int i = 0; i < mq.size(); i++)
                if (mq[i][36:32] == r) res = {1'b1, mq[i][31:0]};
        return res;
    endfunction

    // One clock: the model consumes the inputs present at the edge, then
    // outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        m_acc = m_ready() && !Reset;
        if (Reset) begin
            mq.delete();
        end else begin
            if (mq.size() > 0) void'(mq.pop_front());
            if (m_acc) begin
                if (wb_valid0 && wb_reg0 != 5'd0) mq.push_back({wb_reg0, wb_data0});
                if (wb_valid1 && wb_reg1 != 5'd0) mq.push_back({wb_reg1, wb_data1});
            end
        end
        #1;
    endtask

    task automatic idle();
        wb_valid0 = 1'b0; wb_valid1 = 1'b0;
        wb_reg0 = 5'd0;   wb_reg1 = 5'd0;
        wb_data0 = 32'd0; wb_data1 = 32'd0;
    endtask

    task automatic pair(input logic v0, input logic [4:0] r0, input logic [31:0] d0,
                        input logic v1, input logic [4:0] r1, input logic [31:0] d1);
        wb_valid0 = v0; wb_reg0 = r0; wb_data0 = d0;
        wb_valid1 = v1; wb_reg1 = r1; wb_data1 = d1;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        Reset = 1'b1;
        pair(1'b1, 5'd9, $urandom, 1'b1, 5'd10, $urandom);
        q_reg0 = 5'd9; q_reg1 = 5'd10;
        tick();
        tick();
        Reset = 1'b0;
        idle();
        #1;
        n_vec++; if ({RegWrite, busy, in_ready} !== 3'b001) begin n_err++;
            $display("FAIL reset_flags got=%b exp=001", {RegWrite, busy, in_ready}); end
        n_vec++; if ({WriteReg_WB, WriteData} !== 37'd0) begin n_err++;
            $display("FAIL reset_head got=%0d/%h exp=0/0", WriteReg_WB, WriteData); end
        n_vec++; if ({q_hit0, q_data0, q_hit1, q_data1} !== 66'd0) begin n_err++;
            $display("FAIL reset_lookup got=%b/%h %b/%h exp=0", q_hit0, q_data0, q_hit1, q_data1); end
    endtask

    task automatic test_basic_pair();
        logic [4:0]  er [3] = '{5'd3, 5'd4, 5'd0};
        logic [31:0] ed [3] = '{32'h11, 32'h22, 32'h0};
        pair(1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22);
        tick();
        idle();
        for (int k = 0; k < 3; k++) begin
            n_vec++; if ({RegWrite, WriteReg_WB, WriteData} !== {(k < 2), er[k], ed[k]}) begin n_err++;
                $display("FAIL basic_write%0d got=%b r%0d %h exp=%b r%0d %h", k,
                         RegWrite, WriteReg_WB, WriteData, (k < 2), er[k], ed[k]); end
            tick();
        end
        n_vec++; if (busy !== 1'b0) begin n_err++;
            $display("FAIL basic_busy got=%b exp=0", busy); end
    endtask

    task automatic test_zero_filter();
        pair(1'b1, 5'd0, 32'hDEAD, 1'b1, 5'd5, 32'h55);
        q_reg0 = 5'd0; q_reg1 = 5'd5;
        tick();
        idle();
        n_vec++; if ({RegWrite, WriteReg_WB, WriteData} !== {1'b1, 5'd5, 32'h55}) begin n_err++;
            $display("FAIL zero_write got=%b r%0d %h exp=1 r5 55", RegWrite, WriteReg_WB, WriteData); end
        n_vec++; if ({q_hit0, q_data0} !== 33'd0) begin n_err++;
            $display("FAIL zero_lookup_r0 got=%b/%h exp=0/0", q_hit0, q_data0); end
        n_vec++; if ({q_hit1, q_data1} !== {1'b1, 32'h55}) begin n_err++;
            $display("FAIL zero_lookup_r5 got=%b/%h exp=1/55", q_hit1, q_data1); end
        tick();
        n_vec++; if ({RegWrite, busy} !== 2'b00) begin n_err++;
            $display("FAIL zero_single got=%b exp=00", {RegWrite, busy}); end
    endtask

    task automatic test_backpressure();
        logic [4:0]  pr [6];
        logic [31:0] pd [6];
        int p = 0, w = 0;
        for (int k = 0; k < 6; k++) begin
            pr[k] = 5'(8 + k); pd[k] = $urandom;
        end
        for (int cyc = 0; cyc < 30 && w < 6; cyc++) begin
            if (p < 3) pair(1'b1, pr[2*p], pd[2*p], 1'b1, pr[2*p+1], pd[2*p+1]);
            else idle();
            tick();
            if (m_acc && p < 3) begin
                p++;
                if (p == 2) begin
                    n_vec++; if (in_ready !== 1'b0) begin n_err++;
                        $display("FAIL bp_not_ready got=%b exp=0", in_ready); end
                end
            end
            n_vec++; if (in_ready !== m_ready()) begin n_err++;
                $display("FAIL bp_ready cyc=%0d got=%b exp=%b", cyc, in_ready, m_ready()); end
            if (RegWrite === 1'b1) begin
                n_vec++; if ({WriteReg_WB, WriteData} !== {pr[w], pd[w]}) begin n_err++;
                    $display("FAIL bp_order w=%0d got=r%0d %h exp=r%0d %h", w,
                             WriteReg_WB, WriteData, pr[w], pd[w]); end
                w++;
            end
        end
        idle();
        n_vec++; if (w != 6) begin n_err++;
            $display("FAIL bp_count got=%0d exp=6", w); end
        tick();
        n_vec++; if (busy !== 1'b0) begin n_err++;
            $display("FAIL bp_drained got=%b exp=0", busy); end
    endtask

    task automatic test_same_dest();
        pair(1'b1, 5'd7, 32'd1, 1'b1, 5'd7, 32'd2);
        q_reg0 = 5'd7; q_reg1 = 5'd7;
        tick();
        idle();
        n_vec++; if ({q_hit0, q_data0, q_hit1, q_data1} !== {1'b1, 32'd2, 1'b1, 32'd2}) begin n_err++;
            $display("FAIL same_look_both got=%b/%h %b/%h exp=1/2", q_hit0, q_data0, q_hit1, q_data1); end
        n_vec++; if ({RegWrite, WriteReg_WB, WriteData} !== {1'b1, 5'd7, 32'd1}) begin n_err++;
            $display("FAIL same_write0 got=%b r%0d %h exp=1 r7 1", RegWrite, WriteReg_WB, WriteData); end
        tick();
        n_vec++; if ({q_hit0, q_data0} !== {1'b1, 32'd2}) begin n_err++;
            $display("FAIL same_look_one got=%b/%h exp=1/2", q_hit0, q_data0); end
        n_vec++; if ({RegWrite, WriteReg_WB, WriteData} !== {1'b1, 5'd7, 32'd2}) begin n_err++;
            $display("FAIL same_write1 got=%b r%0d %h exp=1 r7 2", RegWrite, WriteReg_WB, WriteData); end
        tick();
        n_vec++; if ({q_hit0, RegWrite} !== 2'b00) begin n_err++;
            $display("FAIL same_empty got=%b exp=00", {q_hit0, RegWrite}); end
    endtask

    task automatic test_wrap();
        int n = 1, w = 1;
        for (int cyc = 0; cyc < 80 && w <= 10; cyc++) begin
            if (n <= 10 && $urandom_range(0, 2) != 0) begin
                if ($urandom_range(0, 1) == 1)
                    pair(1'b1, 5'(n), 32'h100 + n, 1'b0, 5'd0, 32'd0);
                else
                    pair(1'b0, 5'd0, 32'd0, 1'b1, 5'(n), 32'h100 + n);
            end else begin
                idle();
            end
            tick();
            if (m_acc && (wb_valid0 || wb_valid1)) n++;
            if (RegWrite === 1'b1) begin
                n_vec++; if ({WriteReg_WB, WriteData} !== {5'(w), 32'h100 + w}) begin n_err++;
                    $display("FAIL wrap_order got=r%0d %h exp=r%0d %h", WriteReg_WB, WriteData, w, 32'h100 + w); end
                w++;
            end
        end
        idle();
        n_vec++; if (w != 11) begin n_err++;
            $display("FAIL wrap_count got=%0d exp=10", w - 1); end
    endtask

    task automatic test_reset_mid_drain();
        pair(1'b1, 5'd11, 32'hA1, 1'b1, 5'd12, 32'hA2);
        tick();
        n_vec++; if ({RegWrite, WriteReg_WB} !== {1'b1, 5'd11}) begin n_err++;
            $display("FAIL rmd_first got=%b r%0d exp=1 r11", RegWrite, WriteReg_WB); end
        pair(1'b1, 5'd13, 32'hA3, 1'b1, 5'd14, 32'hA4);
        tick();
        n_vec++; if ({RegWrite, WriteReg_WB} !== {1'b1, 5'd12}) begin n_err++;
            $display("FAIL rmd_second got=%b r%0d exp=1 r12", RegWrite, WriteReg_WB); end
        idle();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        #1;
        n_vec++; if ({RegWrite, busy, in_ready} !== 3'b001) begin n_err++;
            $display("FAIL rmd_cleared got=%b exp=001", {RegWrite, busy, in_ready}); end
        for (int k = 0; k < 4; k++) begin
            tick();
            n_vec++; if (RegWrite !== 1'b0) begin n_err++;
                $display("FAIL rmd_no_write k=%0d got=%b r%0d exp=0", k, RegWrite, WriteReg_WB); end
        end
    endtask

    task automatic test_random();
        logic [32:0] e0, e1;
        for (int cyc = 0; cyc < 400; cyc++) begin
            Reset = ($urandom_range(0, 59) == 0);
            pair($urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom,
                 $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom);
            q_reg0 = 5'($urandom_range(0, 7));
            q_reg1 = 5'($urandom_range(0, 7));
            tick();
            Reset = 1'b0;
            #1;
            e0 = m_look(q_reg0);
            e1 = m_look(q_reg1);
            n_vec++; if ({in_ready, busy, RegWrite} !== {m_ready(), mq.size() > 0, mq.size() > 0}) begin n_err++;
                $display("FAIL rnd_flags cyc=%0d got=%b exp=%b", cyc, {in_ready, busy, RegWrite},
                         {m_ready(), mq.size() > 0, mq.size() > 0}); end
            n_vec++; if ({WriteReg_WB, WriteData} !== {m_head_r(), m_head_d()}) begin n_err++;
                $display("FAIL rnd_head cyc=%0d got=r%0d %h exp=r%0d %h", cyc,
                         WriteReg_WB, WriteData, m_head_r(), m_head_d()); end
            n_vec++; if ({q_hit0, q_data0} !== e0) begin n_err++;
                $display("FAIL rnd_look0 cyc=%0d r%0d got=%b/%h exp=%b/%h", cyc, q_reg0,
                         q_hit0, q_data0, e0[32], e0[31:0]); end
            n_vec++; if ({q_hit1, q_data1} !== e1) begin n_err++;
                $display("FAIL rnd_look1 cyc=%0d r%0d got=%b/%h exp=%b/%h", cyc, q_reg1,
                         q_hit1, q_data1, e1[32], e1[31:0]); end
        end
        idle();
    endtask

    initial begin
        Reset = 1'b0;
        idle();
        q_reg0 = 5'd0; q_reg1 = 5'd0;
        test_reset();
        test_basic_pair();
        test_zero_filter();
        test_backpressure();
        test_same_dest();
        test_wrap();
        test_reset_mid_drain();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule
`default_nettype wire
